// File: rtl/mem_access_unit.sv
// Load/store front-end: byte-addressed LB/LH/LW/SB/SH/SW to a word-addressed memory; sub-word stores by read-modify-write.
// Latency accept->rsp_valid: load 2, word store 2, sub-word store 3, error 1 cycles.
// One request outstanding; req_ready=1 only in IDLE. Optional `MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module mem_access_unit #(
    parameter int DEPTH = 121
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        mem_WE,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    state_t      state, state_nxt;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic        err_q;

    logic        acc;
    logic        req_err;
    logic        misalign;
    logic [1:0]  off_eff;
    logic [31:0] lane;
    logic [31:0] load_ext;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    assign req_ready = (state == IDLE);
    assign acc       = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid && err_q;
    // Write enable is gated by reset so an in-flight WRITE never reaches memory.
    assign mem_WE    = (state == WRITE) && !rst;

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err = (req_size == 2'b11) || (req_addr[31:2] >= DEPTH_W) || misalign;

    // Ignored low address bits are dropped here; with trapping enabled they never reach this point.
    always_comb begin
        off_eff = req_addr[1:0];
        if (req_size == 2'b01)
            off_eff = {req_addr[1], 1'b0};
        else if (req_size == 2'b10)
            off_eff = 2'b00;
    end

    always_comb begin
        lane     = mem_rdata >> {off_q, 3'b000};
        load_ext = lane;
        case (size_q)
            2'b00:   load_ext = {{24{sgn_q & lane[7]}}, lane[7:0]};
            2'b01:   load_ext = {{16{sgn_q & lane[15]}}, lane[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        lane_mask = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        lane_mask = lane_mask << {off_q, 3'b000};
        merged    = (mem_rdata & ~lane_mask) |
                    (({16'h0, wdata_q} << {off_q, 3'b000}) & lane_mask);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (!req_we)
                        state_nxt = LOAD;
                    else if (req_size == 2'b10)
                        state_nxt = WRITE;
                    else
                        state_nxt = MERGE;
                end
            end
            LOAD:    state_nxt = RESP;
            MERGE:   state_nxt = WRITE;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            size_q    <= 2'b00;
            sgn_q     <= 1'b0;
            off_q     <= 2'b00;
            wdata_q   <= 16'h0;
            err_q     <= 1'b0;
            rsp_rdata <= 32'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                size_q  <= req_size;
                sgn_q   <= req_signed;
                off_q   <= off_eff;
                wdata_q <= req_wdata[15:0];
                err_q   <= req_err;
                if (!req_err) begin
                    mem_addr <= {2'b00, req_addr[31:2]};
                    if (req_we && (req_size == 2'b10))
                        mem_wdata <= req_wdata;
                end
            end
            if (state == LOAD)
                rsp_rdata <= load_ext;
            if (state == MERGE)
                mem_wdata <= merged;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed load/store vectors against a behavioural word memory; expected responses and writes go through scoreboard queues.
module tb_mem_access_unit;
    localparam int DEPTH = 121;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_WE;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_access_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .mem_WE(mem_WE), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:DEPTH-1];
    assign mem_rdata = (mem_addr < 32'(DEPTH)) ? mem[mem_addr[6:0]] : 32'h0;
    always @(posedge clk)
        if (mem_WE && (mem_addr < 32'(DEPTH)))
            mem[mem_addr[6:0]] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } rsp_t;

    rsp_t        rq[$];
    int          acq[$];
    logic [63:0] wq[$];

    int total = 0;
    int bad   = 0;
    logic [31:0] held = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response and every memory write must match the head of its queue.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (rq.size() == 0 || acq.size() == 0) begin
                chk("unexpected_rsp", 32'h1, 32'h0);
            end else begin
                rsp_t e;
                int   a;
                e = rq.pop_front();
                a = acq.pop_front();
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_latency", 32'(cyc - a + 1), 32'(e.lat));
            end
        end
        if (mem_WE) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'h1, 32'h0);
            end else begin
                logic [63:0] w;
                w = wq.pop_front();
                chk("write_addr", mem_addr, w[63:32]);
                chk("write_data", mem_wdata, w[31:0]);
            end
        end
    end

    task automatic req(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input int e_lat, input logic [31:0] e_rd,
                       input logic e_wr, input logic [31:0] e_wa, input logic [31:0] e_wd,
                       input logic abandon);
        int n;
        rsp_t e;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'h0, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        if (!abandon) begin
            e.err = e_err; e.rdata = e_rd; e.lat = e_lat;
            rq.push_back(e);
            if (e_wr) wq.push_back({e_wa, e_wd});
        end
        @(posedge clk);
        #1;
        if (!abandon) acq.push_back(cyc);
        // Scramble the request bus to show it is latched at accept.
        req_valid  = 1'b0;
        req_we     = ~we;
        req_size   = ~sz;
        req_signed = ~sg;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h5555_5555;
    endtask

    task automatic ld(input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] exp);
        req(1'b0, sz, sg, a, 32'h0, 1'b0, 2, exp, 1'b0, 32'h0, 32'h0, 1'b0);
        held = exp;
    endtask

    task automatic bad_req(input logic we, input logic [1:0] sz, input logic [31:0] a);
        req(we, sz, 1'b0, a, 32'h1234_5678, 1'b1, 1, held, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] wa, input logic [31:0] wword);
        req(1'b1, sz, 1'b0, a, wd, 1'b0, (sz == 2'b10) ? 2 : 3, held, 1'b1, wa, wword, 1'b0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_we", {31'h0, mem_WE}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        rst = 1'b0;

        st(2'b10, 32'h10, 32'hDEAD_BEEF, 32'd4, 32'hDEAD_BEEF);
        ld(2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        st(2'b00, 32'h12, 32'h0000_005A, 32'd4, 32'hDE5A_BEEF);
        ld(2'b00, 1'b1, 32'h12, 32'h0000_005A);
        ld(2'b01, 1'b1, 32'h12, 32'hFFFF_DE5A);
        ld(2'b01, 1'b0, 32'h12, 32'h0000_DE5A);
        ld(2'b00, 1'b1, 32'h10, 32'hFFFF_FFEF);
        bad_req(1'b0, 2'b10, 32'(DEPTH * 4));
        bad_req(1'b0, 2'b11, 32'h10);
        bad_req(1'b1, 2'b10, 32'(DEPTH * 4 + 4));
`ifdef MISALIGN_TRAP_EN
        bad_req(1'b0, 2'b01, 32'h11);
        bad_req(1'b1, 2'b10, 32'h1D);
        ld(2'b10, 1'b0, 32'h1C, 32'h0000_0000);
`else
        ld(2'b01, 1'b1, 32'h11, 32'hFFFF_BEEF);
        st(2'b10, 32'h1D, 32'hCAFE_F00D, 32'd7, 32'hCAFE_F00D);
        ld(2'b10, 1'b0, 32'h1C, 32'hCAFE_F00D);
`endif
        st(2'b01, 32'h1A, 32'hABCD_1234, 32'd6, 32'h1234_0000);
        ld(2'b00, 1'b0, 32'h1B, 32'h0000_0012);
        ld(2'b01, 1'b1, 32'h1A, 32'h0000_1234);
        st(2'b00, 32'h1E3, 32'hFFFF_FFAB, 32'd120, 32'hAB00_0000);
        ld(2'b00, 1'b1, 32'h1E3, 32'hFFFF_FFAB);

        // Sub-word store abandoned by reset during its WRITE cycle.
        req(1'b1, 2'b01, 1'b0, 32'h10, 32'h7777, 1'b0, 0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        held = 32'h0;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
        chk("post_rst_word4", mem[4], 32'hDE5A_BEEF);
        ld(2'b10, 1'b0, 32'h10, 32'hDE5A_BEEF);

        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("rsp_queue_drained", 32'(rq.size()), 32'h0);
        chk("write_queue_drained", 32'(wq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
